// File: rtl/serial_tc_pkg.sv
// serial_tc_pkg: mode encoding shared by the serial two's-complement unit.
package serial_tc_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {PASS = 2'b00, NEG = 2'b01, ABS = 2'b10, RSVD = 2'b11} mode_t;
endpackage

// File: rtl/serial_neg_cell.sv
// serial_neg_cell: seen_one flop for the LSB-first Mealy negate rule.
module serial_neg_cell (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic seen
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) seen <= 1'b0;
    else seen <= clr ? 1'b0 : en ? (seen | d) : seen;
endmodule

// File: rtl/serial_twos_comp_unit.sv
// serial_twos_comp_unit: LSB-first serial PASS/NEG/ABS with overflow flag.
// Define SERIAL_TC_SAT_EN to saturate the most-negative NEG/ABS word to 0 followed by ones.
module serial_twos_comp_unit
  import serial_tc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_bit,
  input  logic [1:0]  mode,
  output logic        out_valid,
  output logic        out_bit,
  output logic        out_last,
  output logic        ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_WORD = {1'b1, {(WIDTH-1){1'b0}}};
  logic [CW-1:0] cnt, emit_cnt;
  logic [WIDTH-2:0] cap;
  logic [WIDTH-1:0] word, out_reg, load_word;
  mode_t cap_mode;
  logic busy, out_neg, out_ovf, load, last, seen, neg_mode, ovf_w, load_neg;
  assign word = {in_bit, cap};
  assign load = in_valid && cnt == CW'(WIDTH - 1);
  assign last = emit_cnt == CW'(WIDTH - 1);
  assign neg_mode = cap_mode == NEG || (cap_mode == ABS && in_bit);
  assign ovf_w = neg_mode && word == MIN_WORD;
`ifdef SERIAL_TC_SAT_EN
  assign load_word = ovf_w ? ~MIN_WORD : word;
  assign load_neg = neg_mode && !ovf_w;
`else
  assign load_word = word;
  assign load_neg = neg_mode;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt      <= '0;
      cap      <= '0;
      cap_mode <= PASS;
      out_reg  <= '0;
      out_neg  <= 1'b0;
      out_ovf  <= 1'b0;
      emit_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      if (in_valid) begin
        cnt <= load ? '0 : cnt + CW'(1);
        cap <= word[WIDTH-1:1];
        if (cnt == '0) cap_mode <= mode_t'(mode);
      end
      // a new word overrides the final emit cycle of the previous one, so back-to-back output is gapless
      if (load) begin
        out_reg  <= load_word;
        out_neg  <= load_neg;
        out_ovf  <= ovf_w;
        emit_cnt <= '0;
        busy     <= 1'b1;
      end else if (busy) begin
        out_reg  <= out_reg >> 1;
        emit_cnt <= emit_cnt + CW'(1);
        busy     <= !last;
      end
    end
  serial_neg_cell u_neg (
    .clk   (clk),
    .reset (reset),
    .clr   (load),
    .en    (busy),
    .d     (out_reg[0]),
    .seen  (seen)
  );
  assign out_valid = busy;
  assign out_bit   = busy & (out_reg[0] ^ (out_neg & seen));
  assign out_last  = busy & last;
  assign ovf       = busy & last & out_ovf;
endmodule

// File: tb/tb_serial_twos_comp_unit.sv
// tb_serial_twos_comp_unit: scoreboard bench for the serial two's-complement unit.
module tb_serial_twos_comp_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic [1:0] mode = 2'b00;
  logic out_valid, out_bit, out_last, ovf;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nb = 0;
  int run = 0;
  int max_run = 0;
  logic [7:0] acc_word = '0;
  typedef struct {logic [7:0] data; logic ovf; int acc;} exp_t;
  exp_t q[$];
  exp_t cur;

  serial_twos_comp_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .mode      (mode),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] d, input logic [1:0] m, input int acc);
    exp_t e;
    logic neg;
    neg = (m == 2'b01) || (m == 2'b10 && d[7]);
    e.ovf = neg && d == 8'h80;
    e.data = neg ? 8'(-d) : d;
`ifdef SERIAL_TC_SAT_EN
    if (e.ovf) e.data = 8'h7F;
`endif
    e.acc = acc;
    return e;
  endfunction

  task automatic send_bit(input logic b, input logic [1:0] m);
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    in_bit = b;
    mode = m;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      in_bit = 1'b0;
      mode = 2'($urandom);
    end
  endtask

  // mode is scrambled after bit 0 to show it is only sampled at the word start
  task automatic send_word(input logic [7:0] d, input logic [1:0] m, input int gap_at);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i], i == 0 ? m : 2'($urandom));
      if (i == 7) q.push_back(model(d, m, cyc + 1));
      if (i == gap_at) idle(3);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      nb = 0;
      run = 0;
      chk("rst_out", {out_valid, out_bit, out_last, ovf}, 4'b0);
    end else if (out_valid) begin
      run++;
      if (run > max_run) max_run = run;
      if (nb == 0) begin
        chk("unexp", q.size() > 0, 1);
        cur = (q.size() > 0) ? q.pop_front() : '{8'h00, 1'b0, 0};
        chk("latency", cyc, cur.acc);
      end
      acc_word = {out_bit, acc_word[7:1]};
      nb++;
      if (out_last || nb == 8) begin
        chk("last_pos", {out_last, 8'(nb)}, {1'b1, 8'd8});
        chk("word", acc_word, cur.data);
        chk("ovf", ovf, cur.ovf);
        nb = 0;
      end
    end else begin
      run = 0;
      chk("idle", {out_bit, out_last, ovf}, 3'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {out_valid, out_bit, out_last, ovf}, 4'b0);
    #1;
    reset = 1'b1;
    send_word(8'h05, 2'b01, -1); idle(10);
    send_word(8'hF6, 2'b10, -1); idle(10);
    send_word(8'h33, 2'b10, -1); idle(10);
    send_word(8'h80, 2'b01, -1); idle(10);
    send_word(8'h80, 2'b00, -1); idle(10);
    send_word(8'h80, 2'b11, -1); idle(10);
    send_word(8'h80, 2'b10, -1); idle(10);
    send_word(8'h00, 2'b01, -1); idle(10);
    max_run = 0;
    send_word(8'h01, 2'b01, -1);
    send_word(8'h02, 2'b00, -1);
    send_word(8'hFF, 2'b10, -1);
    idle(12);
    chk("b2b_run", max_run, 24);
    send_word(8'h05, 2'b01, 2); idle(10);
    send_word(8'h05, 2'b01, -1);
    for (int i = 0; i < 5; i++) send_bit(1'(8'h3C >> i), 2'b00);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_async", {out_valid, out_bit, out_last, ovf}, 4'b0);
    q.delete();
    idle(2);
    reset = 1'b1;
    send_word(8'hF6, 2'b10, -1); idle(10);
    for (int i = 0; i < 12; i++) send_word(8'($urandom), 2'($urandom), -1);
    idle(12);
    chk("q_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_twos_comp_unit.md
SERIAL_TWOS_COMP_UNIT -- requirements
Module: serial_twos_comp_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the serial word length in bits; the legal range is WIDTH >= 2.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit wide: asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port in_valid SHALL be an input, 1 bit wide: in_bit is accepted on the current edge.
REQ-005 Port in_bit SHALL be an input, 1 bit wide: the serial data bit, sent LSB first.
REQ-006 Port mode SHALL be an input, 2 bits wide, with encoding 00 PASS, 01 NEG, 10 ABS, 11 reserved (11 behaves as PASS).
REQ-007 Port out_valid SHALL be an output, 1 bit wide: out_bit is valid this cycle.
REQ-008 Port out_bit SHALL be an output, 1 bit wide: the serial result bit, sent LSB first.
REQ-009 Port out_last SHALL be an output, 1 bit wide: the current out_bit is the MSB of its word.
REQ-010 Port ovf SHALL be an output, 1 bit wide: the word's result is not representable; ovf is qualified by out_last.

Function
REQ-011 The block SHALL deserialise each WIDTH-bit input word into a capture shift register; a bit counter advances only on edges where in_valid=1.
REQ-012 Gaps in in_valid SHALL hold the counter and the partial word; there is no timeout.
REQ-013 mode SHALL be sampled on the edge that accepts bit 0 of a word and held for that whole word; mode changes mid-word SHALL be ignored.
REQ-014 When bit WIDTH-1 is accepted on edge k, the word and its mode SHALL be transferred to the output register on edge k.
REQ-015 out_valid SHALL be 1 for exactly the WIDTH cycles following edge k, with out_last=1 in the final cycle.
REQ-016 Latency SHALL be fixed: the first output bit is valid in the cycle after the last input bit is accepted, for all modes.
REQ-017 Back-to-back words (continuous in_valid) SHALL produce a continuous out_valid with no gap and no loss; capture and emit proceed concurrently.
REQ-018 PASS mode SHALL give out_bit = the stored bit.
REQ-019 NEG mode SHALL use a Mealy rule: out_bit = bit XOR seen_one, then seen_one |= bit; seen_one is cleared at the start of each emitted word.
REQ-020 ABS mode SHALL apply the NEG rule if the stored MSB = 1, and the PASS rule otherwise.
REQ-021 ovf SHALL be 1 with out_last when the mode is NEG or ABS and the word is 1 followed by WIDTH-1 zeros (most negative); otherwise ovf SHALL be 0.
REQ-022 Outputs other than out_valid SHALL be 0 whenever out_valid=0.

Reset
REQ-023 Asserting reset=0 SHALL immediately clear the counter, capture register, output register, seen_one and the emit counter.
REQ-024 While reset is asserted, out_valid, out_bit, out_last and ovf SHALL all be 0.
REQ-025 Reset asserted mid-word SHALL discard the partial input and truncate any word in emission; after release, the next accepted bit is bit 0.

Configuration
REQ-026 With macro SERIAL_TC_SAT_EN defined, an overflowing NEG/ABS word SHALL be emitted as the saturated value 0 followed by WIDTH-1 ones (0x7F for WIDTH=8), with ovf=1.
REQ-027 Without SERIAL_TC_SAT_EN, an overflowing word SHALL be emitted unchanged (wrap-around result, 0x80 for WIDTH=8) with ovf=1.

Structure
REQ-028 Package serial_tc_pkg SHALL hold the mode typedef/enum (PASS, NEG, ABS, RSVD) and the mode-width constant.
REQ-029 Sub-module serial_neg_cell SHALL implement the one-bit Mealy negate state (seen_one flop with synchronous clear and async reset), and it SHALL be instantiated once.

Verification
REQ-030 WIDTH=8, NEG, input 0x05 (LSB first 1,0,1,0,0,0,0,0) -> output 0xFB, ovf=0, out_last in the 8th output cycle.
REQ-031 ABS with 0xF6 -> 0x0A; ABS with 0x33 -> 0x33; both with ovf=0.
REQ-032 NEG with 0x80 -> ovf=1 and output 0x80, or 0x7F when SERIAL_TC_SAT_EN is defined; PASS with 0x80 -> ovf=0.
REQ-033 Three back-to-back words 0x01/NEG, 0x02/PASS, 0xFF/ABS with in_valid held high for 24 cycles -> out_valid high for 24 contiguous cycles, giving 0xFF, 0x02, 0x01.
REQ-034 Word 0x05/NEG with a 3-cycle in_valid gap after bit 2, and mode toggled during the gap -> output 0xFB, latency unchanged from the last accepted bit.
REQ-035 reset pulsed low after bit 4 of a word, and during emission of the previous word -> out_valid=0 at once; the next 8 accepted bits form a clean new word with the correct result.
